// File: rtl/invaders_pkg.sv
// Shared types and default geometry for the invader formation block.
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARCH,
    LANDED,
    CLEARED
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam int DEF_COLS      = 20;
  localparam int DEF_ROWS      = 4;
  localparam int DEF_LAST_LINE = 13;

endpackage

// File: rtl/invader_formation_step_timer.sv
// Programmable-period tick generator: counts 0..period-1 while enabled, pulses on wrap.
module step_timer #(
  parameter int PW = 17
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [PW-1:0] i_period,
  output logic          o_tick
);

  logic [PW-1:0] r_cnt;
  logic          w_wrap;

  // >= rather than == so a period that shrinks below the running count still wraps
  assign w_wrap = ({1'b0, r_cnt} + (PW + 1)'(1)) >= {1'b0, i_period};
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/invader_formation.sv
// ROWS x COLS invader formation: sideways march, edge descent, speed-up on kills, hit detection.
module invader_formation
  import invaders_pkg::*;
#(
  parameter  int COLS       = DEF_COLS,
  parameter  int ROWS       = DEF_ROWS,
  parameter  int INIT_W     = 9,
  parameter  int LAST_LINE  = DEF_LAST_LINE,
  parameter  int STEP_TICKS = 100000,
  parameter  int SPEEDUP    = 4000,
  parameter  int MIN_TICKS  = 8000,
  localparam int CW         = $clog2(COLS),
  localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int AW         = $clog2(ROWS * COLS + 1)
) (
  input  logic                 clk_36MHz,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bullet_valid,
  input  logic [CW-1:0]        bullet_x,
  input  logic [3:0]           bullet_y,
  output logic                 hit,
  output logic [RW-1:0]        hit_row,
  output logic [CW-1:0]        hit_col,
  output logic [ROWS*COLS-1:0] invaders_map,
  output logic [3:0]           formation_line,
  output logic [AW-1:0]        alive_count,
  output logic                 landed,
  output logic                 cleared
);

  localparam int PMAX = (STEP_TICKS > MIN_TICKS) ? STEP_TICKS : MIN_TICKS;
  localparam int PW   = $clog2(PMAX + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [COLS-1:0] r_rows [ROWS];
  logic [COLS-1:0] w_rows_hit [ROWS];
  logic [COLS-1:0] w_rows_next [ROWS];
  logic [COLS-1:0] w_init;
  logic [3:0]     r_line;
  logic [3:0]     w_line_next;
  logic           r_dir;
  logic           w_dir_next;
  logic [AW-1:0]  r_alive;
  logic [AW-1:0]  w_alive_next;
  logic           r_hit;
  logic [RW-1:0]  r_hit_row;
  logic [CW-1:0]  r_hit_col;

  logic           w_hit;
  logic [RW-1:0]  w_hit_row;
  logic [3:0]     w_rel;
  logic           w_any_msb;
  logic           w_any_lsb;
  logic           w_desc;
  logic           w_land;
  logic           w_tick;
  logic [31:0]    w_kills;
  logic [31:0]    w_dec;
  logic [PW-1:0]  w_period;

  always_comb begin
    w_init = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      w_init[c] = (c < INIT_W);
    end
  end

  // Period derived at 32 bits and clamped before narrowing, so it can never wrap
  always_comb begin
    w_kills  = 32'(ROWS * INIT_W) - 32'(r_alive);
    w_dec    = w_kills * 32'(SPEEDUP);
    w_period = PW'(MIN_TICKS);
    if (w_dec < 32'(STEP_TICKS) && (32'(STEP_TICKS) - w_dec) > 32'(MIN_TICKS)) begin
      w_period = PW'(32'(STEP_TICKS) - w_dec);
    end
  end

  step_timer #(
    .PW(PW)
  ) u_step_timer (
    .i_clk   (clk_36MHz),
    .i_rst   (reset),
    .i_en    (r_state == MARCH),
    .i_period(w_period),
    .o_tick  (w_tick)
  );

  // Hit detection by full comparison so no out-of-range index is ever formed
  always_comb begin
    w_hit     = 1'b0;
    w_hit_row = '0;
    w_rel     = bullet_y - r_line;
    for (int unsigned r = 0; r < ROWS; r++) begin
      w_rows_hit[r] = r_rows[r];
    end
    if (r_state == MARCH && bullet_valid && bullet_y >= r_line &&
        32'(w_rel) < ROWS && 32'(bullet_x) < COLS) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (w_rel == 4'(r) && bullet_x == CW'(c) && r_rows[r][c]) begin
            w_hit            = 1'b1;
            w_hit_row        = RW'(r);
            w_rows_hit[r][c] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_any_msb = 1'b0;
    w_any_lsb = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      w_any_msb = w_any_msb | w_rows_hit[r][COLS-1];
      w_any_lsb = w_any_lsb | w_rows_hit[r][0];
    end
  end

  always_comb begin
    w_desc      = 1'b0;
    w_line_next = r_line;
    w_dir_next  = r_dir;
    for (int unsigned r = 0; r < ROWS; r++) begin
      w_rows_next[r] = w_rows_hit[r];
    end
    if (w_tick) begin
      if ((r_dir == LEFT && w_any_msb) || (r_dir == RIGHT && w_any_lsb)) begin
        w_desc     = 1'b1;
        w_dir_next = ~r_dir;
        if (32'(r_line) < LAST_LINE) begin
          w_line_next = r_line + 4'd1;
        end
      end else begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          w_rows_next[r] = (r_dir == LEFT) ? {w_rows_hit[r][COLS-2:0], 1'b0}
                                           : {1'b0, w_rows_hit[r][COLS-1:1]};
        end
      end
    end
    w_land = w_desc && ((32'(w_line_next) + ROWS - 1) >= LAST_LINE);
  end

  assign w_alive_next = r_alive - AW'(w_hit);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = MARCH;
        end
      end
      MARCH: begin
        if (w_alive_next == '0) begin
          w_state_next = CLEARED;
        end else if (w_land) begin
          w_state_next = LANDED;
        end
      end
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_line    <= 4'd1;
      r_dir     <= LEFT;
      r_alive   <= AW'(ROWS * INIT_W);
      r_hit     <= 1'b0;
      r_hit_row <= '0;
      r_hit_col <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        r_rows[r] <= w_init;
      end
    end else begin
      r_state <= w_state_next;
      r_line  <= w_line_next;
      r_dir   <= w_dir_next;
      r_alive <= w_alive_next;
      r_hit   <= w_hit;
      if (w_hit) begin
        r_hit_row <= w_hit_row;
        r_hit_col <= bullet_x;
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
        r_rows[r] <= w_rows_next[r];
      end
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_map
    assign invaders_map[g*COLS +: COLS] = r_rows[g];
  end

  assign hit            = r_hit;
  assign hit_row        = r_hit_row;
  assign hit_col        = r_hit_col;
  assign formation_line = r_line;
  assign alive_count    = r_alive;
  assign landed         = (r_state == LANDED);
  assign cleared        = (r_state == CLEARED);

endmodule

// File: tb/tb_invader_formation.sv
// Randomized bench for invader_formation against an invader-position reference model.
module tb_invader_formation;

  localparam int T_COLS  = 8;
  localparam int T_ROWS  = 2;
  localparam int T_INIT  = 3;
  localparam int T_LAST  = 6;
  localparam int T_STEP  = 10;
  localparam int T_SPD   = 2;
  localparam int T_MIN   = 4;
  localparam int T_TOTAL = T_ROWS * T_INIT;

  logic        clk_36MHz = 1'b0;
  logic        reset;
  logic        start;
  logic        bullet_valid;
  logic [2:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic        hit;
  logic [0:0]  hit_row;
  logic [2:0]  hit_col;
  logic [15:0] invaders_map;
  logic [3:0]  formation_line;
  logic [4:0]  alive_count;
  logic        landed;
  logic        cleared;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each invader keeps its starting column; the formation has one column offset.
  bit m_alive [T_ROWS][T_INIT];
  int m_off, m_line, m_dir, m_cnt, m_count;
  int m_mode;  // 0 waiting, 1 marching, 2 landed, 3 cleared
  int m_hit, m_hr, m_hc;

  invader_formation #(
    .COLS(T_COLS), .ROWS(T_ROWS), .INIT_W(T_INIT), .LAST_LINE(T_LAST),
    .STEP_TICKS(T_STEP), .SPEEDUP(T_SPD), .MIN_TICKS(T_MIN)
  ) dut (
    .clk_36MHz(clk_36MHz), .reset(reset), .start(start),
    .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .hit(hit), .hit_row(hit_row), .hit_col(hit_col),
    .invaders_map(invaders_map), .formation_line(formation_line),
    .alive_count(alive_count), .landed(landed), .cleared(cleared)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_map();
    logic [15:0] m = '0;
    for (int r = 0; r < T_ROWS; r++)
      for (int c = 0; c < T_INIT; c++)
        if (m_alive[r][c]) m[r*T_COLS + c + m_off] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < T_ROWS; r++)
      for (int c = 0; c < T_INIT; c++) m_alive[r][c] = 1'b1;
    m_off = 0; m_line = 1; m_dir = 0; m_cnt = 0; m_count = T_TOTAL;
    m_mode = 0; m_hit = 0; m_hr = 0; m_hc = 0;
  endtask

  task automatic model_step();
    int per, r, c, lo, hi, desc;
    m_hit = 0;
    if (m_mode == 1) begin
      per = T_STEP - T_SPD * (T_TOTAL - m_count);
      if (per < T_MIN) per = T_MIN;
      if (bullet_valid && int'(bullet_y) >= m_line && int'(bullet_y) - m_line < T_ROWS) begin
        r = int'(bullet_y) - m_line;
        c = int'(bullet_x) - m_off;
        if (c >= 0 && c < T_INIT && m_alive[r][c]) begin
          m_alive[r][c] = 1'b0;
          m_hit = 1; m_hr = r; m_hc = int'(bullet_x);
          m_count--;
        end
      end
      desc = 0;
      m_cnt++;
      if (m_cnt >= per) begin
        m_cnt = 0;
        lo = T_COLS; hi = -1;
        for (int rr = 0; rr < T_ROWS; rr++)
          for (int cc = 0; cc < T_INIT; cc++)
            if (m_alive[rr][cc]) begin
              if (cc + m_off < lo) lo = cc + m_off;
              if (cc + m_off > hi) hi = cc + m_off;
            end
        if ((m_dir == 0 && hi == T_COLS - 1) || (m_dir == 1 && lo == 0)) begin
          desc = 1;
          if (m_line < T_LAST) m_line++;
          m_dir = 1 - m_dir;
        end else begin
          m_off += (m_dir == 0) ? 1 : -1;
        end
      end
      if (m_count == 0) m_mode = 3;
      else if (desc && m_line + T_ROWS - 1 >= T_LAST) m_mode = 2;
    end else if (m_mode == 0 && start) begin
      m_mode = 1;
    end
  endtask

  task automatic compare_all();
    check("map", invaders_map, model_map());
    check("line", formation_line, m_line);
    check("hit", hit, m_hit);
    check("hit_row", hit_row, m_hr);
    check("hit_col", hit_col, m_hc);
    check("alive", alive_count, m_count);
    check("landed", landed, m_mode == 2);
    check("cleared", cleared, m_mode == 3);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_36MHz);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bullet_valid = 1'b0; bullet_x = '0; bullet_y = '0;
    model_reset();
    @(posedge clk_36MHz);
    @(negedge clk_36MHz);
    reset = 1'b0;
  endtask

  task automatic aim_random();
    int q[$];
    int k, r, c;
    for (int rr = 0; rr < T_ROWS; rr++)
      for (int cc = 0; cc < T_INIT; cc++)
        if (m_alive[rr][cc]) q.push_back(rr * T_INIT + cc);
    if (q.size() == 0) begin
      bullet_valid = 1'b0;
    end else begin
      k = q[$urandom_range(q.size() - 1)];
      r = k / T_INIT; c = k % T_INIT;
      bullet_valid = 1'b1;
      bullet_x = 3'(c + m_off);
      bullet_y = 4'(m_line + r);
    end
  endtask

  task automatic episode(input int max_cyc, input int aim_pct, input int stray_pct, input int rst_at);
    int roll, tail;
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    tail = 0;
    for (int i = 0; i < max_cyc && tail < 12; i++) begin
      roll = $urandom_range(99);
      start = ($urandom_range(9) == 0);
      if (roll < aim_pct) aim_random();
      else if (roll < aim_pct + stray_pct) begin
        bullet_valid = 1'b1;
        bullet_x = 3'($urandom_range(7));
        bullet_y = 4'($urandom_range(15));
      end else bullet_valid = 1'b0;
      if (i == rst_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_map", invaders_map, 16'h0707);
        check("rst_line", formation_line, 1);
        check("rst_hit", hit, 0);
        check("rst_alive", alive_count, T_TOTAL);
        check("rst_lc", {landed, cleared}, 0);
        check("rst_hitpos", {hit_row, hit_col}, 0);
        do_reset();
        return;
      end
      cycle();
      if (m_mode >= 2) tail++;
    end
    check("episode_end", m_mode >= 2, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    #1;
    compare_all();
    check("reset_map", invaders_map, 16'h0707);

    // idle with bullets flying: nothing moves, nothing dies
    for (int i = 0; i < 50; i++) begin
      bullet_valid = $urandom_range(1);
      bullet_x = 3'($urandom_range(7));
      bullet_y = 4'($urandom_range(3));
      cycle();
    end
    check("idle_map", invaders_map, 16'h0707);
    check("idle_line", formation_line, 1);

    // plain march: 1 step, 5 steps, then descent
    bullet_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("step1_map", invaders_map, 16'h0E0E);
    for (int i = 0; i < 40; i++) cycle();
    check("step5_map", invaders_map, 16'hE0E0);
    for (int i = 0; i < 10; i++) cycle();
    check("step6_map", invaders_map, 16'hE0E0);
    check("step6_line", formation_line, 2);

    // directed kill at reset position
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    bullet_valid = 1'b1; bullet_x = 3'd1; bullet_y = 4'd2;
    cycle();
    bullet_valid = 1'b0;
    check("kill_hit", hit, 1);
    check("kill_pos", {hit_row, hit_col}, 4'b1001);
    check("kill_map", invaders_map, 16'h0507);
    check("kill_alive", alive_count, 5);
    cycle();
    check("kill_pulse", hit, 0);
    check("kill_hold", hit_col, 1);

    for (int e = 0; e < 4; e++) episode(600, 30, 10, -1);
    for (int e = 0; e < 4; e++) episode(600, 4, 20, -1);
    for (int e = 0; e < 2; e++) episode(600, 0, 30, -1);
    episode(600, 10, 10, 37);
    episode(600, 0, 0, 143);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
